// File: rtl/core101_pkg.sv
// Shared core types: architectural widths and the writeback entry carried
// between execute and the GPR write port.
package core101_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/gpr_wb_fifo.sv
// Small synchronous FIFO buffering ALU writeback entries; power-of-two depth,
// pointers wrap naturally, push is ignored when full and pop when empty.
module gpr_wb_fifo
  import core101_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = wb_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clock_in,
  input  logic             reset_in,
  input  logic             push,
  input  entry_t           push_entry,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: non-blocking (<=) for every registered signal so all flops sample
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are meaningful, so clearing the array buys nothing.
  always_ff @(posedge clock_in) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/gpr_writeback.sv
// GPR writeback stage: merges buffered ALU results with priority loads into a
// single registered write port, filters x0 and tracks per-register busy bits.
module gpr_writeback
  import core101_pkg::*;
#(
  parameter int  DATA_WIDTH = XLEN,
  parameter int  ADDR_WIDTH = REG_ADDR_W,
  parameter int  FIFO_DEPTH = 4,
  localparam int NUM_R      = 2 ** ADDR_WIDTH,
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  input  logic                  issue_valid_in,
  input  logic [ADDR_WIDTH-1:0] issue_rd_addr_in,
  input  logic                  exe_valid_in,
  output logic                  exe_ready_out,
  input  logic [ADDR_WIDTH-1:0] exe_rd_addr_in,
  input  logic [DATA_WIDTH-1:0] exe_data_in,
  input  logic                  load_valid_in,
  input  logic [ADDR_WIDTH-1:0] load_rd_addr_in,
  input  logic [DATA_WIDTH-1:0] load_data_in,
  output logic                  gpr_write_enable_out,
  output logic [ADDR_WIDTH-1:0] gpr_rd_addr_out,
  output logic [DATA_WIDTH-1:0] gpr_rd_data_out,
  output logic [NUM_R-1:0]      busy_mask_out,
  output logic [CNT_W-1:0]      fifo_count_out
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t           push_entry;
  entry_t           fifo_head;
  entry_t           sel_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic             load_sel;
  logic             sel_valid;
  logic [NUM_R-1:0] busy_next;

  // Ready depends only on the registered count, never on a same-cycle pop.
  assign exe_ready_out = ~reset_in & ~fifo_full;
  assign fifo_push     = exe_valid_in & exe_ready_out & (exe_rd_addr_in != '0);
  assign push_entry    = '{rd: exe_rd_addr_in, data: exe_data_in};
  assign load_sel      = load_valid_in & (load_rd_addr_in != '0);

  gpr_wb_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .entry_t(entry_t)
  ) u_fifo (
    .clock_in  (clock_in),
    .reset_in  (reset_in),
    .push      (fifo_push),
    .push_entry(push_entry),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_out)
  );

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel_entry = fifo_head;
    fifo_pop  = 1'b0;
    if (load_sel) begin
      sel_valid = 1'b1;
      sel_entry = '{rd: load_rd_addr_in, data: load_data_in};
    end else if (!fifo_empty) begin
      sel_valid = 1'b1;
      fifo_pop  = 1'b1;
    end
  end

  // Address and data hold their last value when no write is issued.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      gpr_write_enable_out <= 1'b0;
      gpr_rd_addr_out      <= '0;
      gpr_rd_data_out      <= '0;
    end else if (sel_valid) begin
      gpr_write_enable_out <= 1'b1;
      gpr_rd_addr_out      <= sel_entry.rd;
      gpr_rd_data_out      <= sel_entry.data;
    end else begin
      gpr_write_enable_out <= 1'b0;
    end
  end

  // Clear on commit first, then set on issue, so a same-cycle set wins.
  always_comb begin
    busy_next = busy_mask_out;
    if (gpr_write_enable_out) busy_next[gpr_rd_addr_out] = 1'b0;
    if (issue_valid_in)       busy_next[issue_rd_addr_in] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) busy_mask_out <= '0;
    else          busy_mask_out <= busy_next;
  end

  waw_issue_check: assert property (@(posedge clock_in) disable iff (reset_in)
    !(issue_valid_in && (issue_rd_addr_in != '0) && busy_mask_out[issue_rd_addr_in] &&
      !(gpr_write_enable_out && (gpr_rd_addr_out == issue_rd_addr_in))));

  x0_write_check: assert property (@(posedge clock_in) disable iff (reset_in)
    !(gpr_write_enable_out && (gpr_rd_addr_out == '0)));

endmodule
